// File: rtl/warp_fetcher.sv
// Warp fetch stage: per-warp PC/mask tracking, round-robin warp pick,
// one registered fetch request per warp toward the instruction cache.
module warp_fetcher #(
    parameter int NumWarps  = 8,
    parameter int WarpWidth = 32,
    parameter int PcWidth   = 32,
    parameter int WidWidth  = $clog2(NumWarps)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 launch_valid_i,
    output logic                 launch_ready_o,
    input  logic [PcWidth-1:0]   launch_pc_i,
    input  logic [WarpWidth-1:0] launch_act_mask_i,
    input  logic [NumWarps-1:0]  ib_space_i,
    input  logic                 upd_valid_i,
    input  logic [WidWidth-1:0]  upd_warp_id_i,
    input  logic [PcWidth-1:0]   upd_pc_i,
    input  logic [WarpWidth-1:0] upd_act_mask_i,
    input  logic                 upd_done_i,
    input  logic                 ic_ready_i,
    output logic                 fe_valid_o,
    output logic [PcWidth-1:0]   fe_pc_o,
    output logic [WarpWidth-1:0] fe_act_mask_o,
    output logic [WidWidth-1:0]  fe_warp_id_o,
    output logic [NumWarps-1:0]  warp_active_o,
    output logic                 all_idle_o
);

    typedef enum logic [1:0] {
        W_IDLE,
        W_READY,
        W_WAIT
    } wstate_e;

    wstate_e              st_q   [NumWarps];
    wstate_e              st_d   [NumWarps];
    logic [PcWidth-1:0]   pc_q   [NumWarps];
    logic [PcWidth-1:0]   pc_d   [NumWarps];
    logic [WarpWidth-1:0] mask_q [NumWarps];
    logic [WarpWidth-1:0] mask_d [NumWarps];

    logic [NumWarps-1:0]  idle_vec;
    logic [NumWarps-1:0]  elig_vec;
    logic                 launch_hit;
    logic                 sel_hit;
    logic                 upd_hit;
    logic                 load;
    logic                 take;
    logic [WidWidth-1:0]  launch_id;
    logic [WidWidth-1:0]  sel_id;
    logic [WidWidth-1:0]  probe;
    logic [WidWidth-1:0]  rr_q;
    logic [WidWidth-1:0]  rr_d;

    always_comb begin
        idle_vec = '0;
        elig_vec = '0;
        for (int i = 0; i < NumWarps; i++) begin
            idle_vec[i] = (st_q[i] == W_IDLE);
            elig_vec[i] = (st_q[i] == W_READY) & ib_space_i[i];
        end
    end

    assign warp_active_o  = ~idle_vec;
    assign launch_ready_o = |idle_vec;
    assign all_idle_o     = (&idle_vec) & ~fe_valid_o;

    // Descending scan so the lowest-index idle slot wins.
    always_comb begin
        launch_hit = 1'b0;
        launch_id  = '0;
        for (int i = NumWarps - 1; i >= 0; i--) begin
            if (idle_vec[i]) begin
                launch_hit = 1'b1;
                launch_id  = WidWidth'(i);
            end
        end
    end

    // NumWarps is a power of two, so the probe index wraps for free.
    always_comb begin
        sel_hit = 1'b0;
        sel_id  = '0;
        probe   = '0;
        for (int k = 0; k < NumWarps; k++) begin
            probe = rr_q + WidWidth'(k);
            if (!sel_hit && elig_vec[probe]) begin
                sel_hit = 1'b1;
                sel_id  = probe;
            end
        end
    end

    assign load    = ~fe_valid_o | ic_ready_i;
    assign take    = load & sel_hit;
    assign upd_hit = upd_valid_i & (st_q[upd_warp_id_i] == W_WAIT);

    // Launch, update and select always touch warps in distinct states.
    always_comb begin
        for (int i = 0; i < NumWarps; i++) begin
            st_d[i]   = st_q[i];
            pc_d[i]   = pc_q[i];
            mask_d[i] = mask_q[i];
        end
        rr_d = rr_q;
        if (launch_valid_i && launch_hit) begin
            st_d[launch_id]   = W_READY;
            pc_d[launch_id]   = launch_pc_i;
            mask_d[launch_id] = launch_act_mask_i;
        end
        if (upd_hit) begin
            if (upd_done_i) begin
                st_d[upd_warp_id_i] = W_IDLE;
            end else begin
                st_d[upd_warp_id_i]   = W_READY;
                pc_d[upd_warp_id_i]   = upd_pc_i;
                mask_d[upd_warp_id_i] = upd_act_mask_i;
            end
        end
        if (take) begin
            st_d[sel_id] = W_WAIT;
            rr_d         = sel_id + WidWidth'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumWarps; i++) begin
                st_q[i]   <= W_IDLE;
                pc_q[i]   <= '0;
                mask_q[i] <= '0;
            end
            rr_q <= '0;
        end else begin
            for (int i = 0; i < NumWarps; i++) begin
                st_q[i]   <= st_d[i];
                pc_q[i]   <= pc_d[i];
                mask_q[i] <= mask_d[i];
            end
            rr_q <= rr_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fe_valid_o    <= 1'b0;
            fe_pc_o       <= '0;
            fe_act_mask_o <= '0;
            fe_warp_id_o  <= '0;
        end else if (load) begin
            fe_valid_o <= sel_hit;
            if (sel_hit) begin
                fe_pc_o       <= pc_q[sel_id];
                fe_act_mask_o <= mask_q[sel_id];
                fe_warp_id_o  <= sel_id;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!rst_i && upd_valid_i) begin
            assert (st_q[upd_warp_id_i] == W_WAIT)
            else $error("update to warp %0d which is not waiting", upd_warp_id_i);
        end
    end
`endif

endmodule

// File: tb/tb_warp_fetcher.sv
// Directed bench for warp_fetcher: expected fetches queued by stimulus,
// popped and compared by an independent monitor on every transfer.
module tb_warp_fetcher;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        launch_valid_i = 1'b0;
    logic        launch_ready_o;
    logic [31:0] launch_pc_i = '0;
    logic [31:0] launch_act_mask_i = '0;
    logic [7:0]  ib_space_i = '0;
    logic        upd_valid_i = 1'b0;
    logic [2:0]  upd_warp_id_i = '0;
    logic [31:0] upd_pc_i = '0;
    logic [31:0] upd_act_mask_i = '0;
    logic        upd_done_i = 1'b0;
    logic        ic_ready_i = 1'b0;
    logic        fe_valid_o;
    logic [31:0] fe_pc_o;
    logic [31:0] fe_act_mask_o;
    logic [2:0]  fe_warp_id_o;
    logic [7:0]  warp_active_o;
    logic        all_idle_o;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] mask;
        logic [2:0]  id;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_exp;
    exp_t e_got;
    int   checks = 0;
    int   errors = 0;
    int   xfers = 0;
    int   auto_upd = 0;
    int   base;

    warp_fetcher dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .launch_valid_i    (launch_valid_i),
        .launch_ready_o    (launch_ready_o),
        .launch_pc_i       (launch_pc_i),
        .launch_act_mask_i (launch_act_mask_i),
        .ib_space_i        (ib_space_i),
        .upd_valid_i       (upd_valid_i),
        .upd_warp_id_i     (upd_warp_id_i),
        .upd_pc_i          (upd_pc_i),
        .upd_act_mask_i    (upd_act_mask_i),
        .upd_done_i        (upd_done_i),
        .ic_ready_i        (ic_ready_i),
        .fe_valid_o        (fe_valid_o),
        .fe_pc_o           (fe_pc_o),
        .fe_act_mask_o     (fe_act_mask_o),
        .fe_warp_id_o      (fe_warp_id_o),
        .warp_active_o     (warp_active_o),
        .all_idle_o        (all_idle_o)
    );

    initial forever #5 clk_i = ~clk_i;

    // Monitor: a transfer happens at the next rising edge.
    initial forever begin
        @(negedge clk_i);
        if (!rst_i && fe_valid_o && ic_ready_i) begin
            xfers++;
            checks++;
            e_got = '{pc: fe_pc_o, mask: fe_act_mask_o, id: fe_warp_id_o};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL xfer: unexpected pc=%h mask=%h id=%0d",
                         fe_pc_o, fe_act_mask_o, fe_warp_id_o);
            end else begin
                e_exp = exp_q.pop_front();
                if (e_got !== e_exp) begin
                    errors++;
                    $display("FAIL xfer: got pc=%h mask=%h id=%0d expected pc=%h mask=%h id=%0d",
                             e_got.pc, e_got.mask, e_got.id, e_exp.pc, e_exp.mask, e_exp.id);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [2:0] id, input logic [31:0] pc, input logic [31:0] mask);
        exp_q.push_back('{pc: pc, mask: mask, id: id});
    endtask

    // One clock; optionally answers the pending fetch with pc+4.
    task automatic tick();
        if (auto_upd > 0 && fe_valid_o && ic_ready_i) begin
            upd_valid_i    = 1'b1;
            upd_done_i     = 1'b0;
            upd_warp_id_i  = fe_warp_id_o;
            upd_pc_i       = fe_pc_o + 32'd4;
            upd_act_mask_i = fe_act_mask_o;
            auto_upd--;
        end
        @(posedge clk_i);
        #1;
        upd_valid_i = 1'b0;
        upd_done_i  = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic launch(input logic [31:0] pc, input logic [31:0] mask);
        launch_valid_i    = 1'b1;
        launch_pc_i       = pc;
        launch_act_mask_i = mask;
        tick();
        launch_valid_i = 1'b0;
    endtask

    task automatic upd(input logic [2:0] id, input logic [31:0] pc,
                       input logic [31:0] mask, input logic done);
        upd_valid_i    = 1'b1;
        upd_warp_id_i  = id;
        upd_pc_i       = pc;
        upd_act_mask_i = mask;
        upd_done_i     = done;
        tick();
    endtask

    initial begin
        ticks(3);
        rst_i = 1'b0;
        ticks(2);
        chk("rst_state", {fe_valid_o, launch_ready_o, all_idle_o, warp_active_o, fe_pc_o},
            {3'b011, 8'h00, 32'h0});

        // Single warp: two-cycle latency, blocked until updated.
        ib_space_i = 8'hFF;
        ic_ready_i = 1'b1;
        push(3'd0, 32'h10, 32'hFFFF_FFFF);
        launch(32'h10, 32'hFFFF_FFFF);
        chk("lat_e0", {fe_valid_o, warp_active_o}, {1'b0, 8'h01});
        tick();
        chk("lat_e1", {fe_valid_o, fe_warp_id_o, fe_pc_o}, {1'b1, 3'd0, 32'h10});
        ticks(4);
        chk("blocked", fe_valid_o, 1'b0);
        push(3'd0, 32'h11, 32'hFFFF_FFFF);
        upd(3'd0, 32'h11, 32'hFFFF_FFFF, 1'b0);
        tick();
        chk("refetch", {fe_valid_o, fe_pc_o}, {1'b1, 32'h11});
        tick();

        // Back-pressure hold.
        ic_ready_i = 1'b0;
        push(3'd0, 32'h20, 32'h0000_FFFF);
        upd(3'd0, 32'h20, 32'h0000_FFFF, 1'b0);
        tick();
        for (int i = 0; i < 6; i++) begin
            chk("hold_pc", fe_pc_o, 32'h20);
            chk("hold_ctl", {fe_valid_o, fe_warp_id_o, fe_act_mask_o},
                {1'b1, 3'd0, 32'h0000_FFFF});
            if (i < 5) tick();
        end
        base = xfers;
        ic_ready_i = 1'b1;
        ticks(2);
        chk("one_xfer", {fe_valid_o, 32'(xfers - base)}, {1'b0, 32'd1});
        upd(3'd0, 32'h0, 32'h0, 1'b1);
        chk("retire0", {all_idle_o, warp_active_o}, {1'b1, 8'h00});

        // Round-robin over four warps, one request per cycle.
        base = xfers;
        for (int w = 0; w < 4; w++)
            push(3'(w), 32'(w + 1) << 8, 32'hF0F0_0000 | 32'(w));
        for (int w = 0; w < 4; w++)
            push(3'(w), (32'(w + 1) << 8) + 32'd4, 32'hF0F0_0000 | 32'(w));
        auto_upd = 4;
        for (int w = 0; w < 4; w++)
            launch(32'(w + 1) << 8, 32'hF0F0_0000 | 32'(w));
        ticks(6);
        chk("rr_rate", {fe_valid_o, 32'(xfers - base)}, {1'b0, 32'd8});
        for (int w = 0; w < 4; w++) upd(3'(w), 32'h0, 32'h0, 1'b1);
        chk("rr_retire", warp_active_o, 8'h00);

        // Warp 1 starved of buffer space is skipped.
        base = xfers;
        ib_space_i = 8'hFD;
        push(3'd0, 32'h100, 32'hF0F0_0000);
        push(3'd2, 32'h300, 32'hF0F0_0002);
        push(3'd3, 32'h400, 32'hF0F0_0003);
        push(3'd0, 32'h104, 32'hF0F0_0000);
        push(3'd2, 32'h304, 32'hF0F0_0002);
        push(3'd3, 32'h404, 32'hF0F0_0003);
        auto_upd = 3;
        for (int w = 0; w < 4; w++)
            launch(32'(w + 1) << 8, 32'hF0F0_0000 | 32'(w));
        ticks(8);
        chk("ib_skip", 32'(xfers - base), 32'd6);
        push(3'd1, 32'h200, 32'hF0F0_0001);
        ib_space_i = 8'hFF;
        ticks(3);

        // Fill all slots, retire warp 5, relaunch into it.
        for (int w = 4; w < 8; w++)
            push(3'(w), 32'(w + 1) << 8, 32'(w));
        for (int w = 4; w < 8; w++)
            launch(32'(w + 1) << 8, 32'(w));
        chk("full", {launch_ready_o, warp_active_o}, {1'b0, 8'hFF});
        ticks(5);
        upd(3'd5, 32'h0, 32'h0, 1'b1);
        chk("retire5", {launch_ready_o, warp_active_o}, {1'b1, 8'hDF});
        push(3'd5, 32'h900, 32'h5555_0005);
        launch(32'h900, 32'h5555_0005);
        chk("relaunch", {launch_ready_o, warp_active_o}, {1'b0, 8'hFF});
        ticks(3);

        // Reset while a request is pending.
        ic_ready_i = 1'b0;
        upd(3'd0, 32'h700, 32'h1, 1'b0);
        tick();
        chk("pend", {fe_valid_o, fe_pc_o}, {1'b1, 32'h700});
        #2;
        rst_i = 1'b1;
        #1;
        chk("async_rst", {fe_valid_o, warp_active_o, fe_warp_id_o, fe_pc_o},
            {1'b0, 8'h00, 3'd0, 32'h0});
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        ic_ready_i = 1'b1;
        chk("post_rst", {launch_ready_o, all_idle_o}, 2'b11);
        push(3'd0, 32'h40, 32'hA5A5_A5A5);
        launch(32'h40, 32'hA5A5_A5A5);
        ticks(4);
        chk("drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/warp_fetcher.md
Name: warp_fetcher

Overview:
Per-compute-unit fetch stage. Tracks one program counter and active mask per warp and picks a ready warp round-robin. Issues one fetch request per warp into the instruction cache over the fe_valid/ic_ready handshake. A warp stays blocked after issuing until decode/branch resolution returns its next PC, or retires it.

Parameters:
NumWarps, 8, warps per compute unit (power of two, >=2)
WarpWidth, 32, threads per warp (active-mask width)
PcWidth, 32, program counter width
WidWidth, $clog2(NumWarps), dependent, do not override

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
launch_valid_i  in  1  request to start a new warp
launch_ready_o  out  1  at least one warp slot IDLE
launch_pc_i  in  PcWidth  start PC of launched warp
launch_act_mask_i  in  WarpWidth  initial active mask
ib_space_i  in  NumWarps  per-warp instruction-buffer space available, fetch allowed
upd_valid_i  in  1  next-PC update from decode/branch
upd_warp_id_i  in  WidWidth  warp being updated
upd_pc_i  in  PcWidth  next PC
upd_act_mask_i  in  WarpWidth  next active mask
upd_done_i  in  1  warp finished; retire instead of refetch
ic_ready_i  in  1  instruction cache accepts request
fe_valid_o  out  1  fetch request valid
fe_pc_o  out  PcWidth  fetch PC
fe_act_mask_o  out  WarpWidth  active mask of fetched warp
fe_warp_id_o  out  WidWidth  fetched warp id
warp_active_o  out  NumWarps  per-warp state != IDLE
all_idle_o  out  1  all warps IDLE and fe_valid_o low

Behaviour:
- Per-warp state: IDLE, READY, WAITING; per-warp pc and act_mask registers.
- Reset (async, any time, incl. mid-transfer): all warps IDLE, pc/mask 0, rr pointer 0, fe_valid_o 0, fe_pc_o/fe_act_mask_o/fe_warp_id_o 0. launch_ready_o=1 and all_idle_o=1 while out of reset.
- Launch: launch_ready_o = any warp IDLE. On launch_valid_i & launch_ready_o, the lowest-index IDLE warp takes launch_pc_i/launch_act_mask_i and becomes READY at the edge.
- Eligible set = READY & ib_space_i. Round-robin: first eligible index at or after rr pointer, wrapping modulo NumWarps.
- Output register: loads when fe_valid_o=0 or (fe_valid_o & ic_ready_i). If an eligible warp exists, the register loads its pc/mask/id and sets fe_valid_o=1. The selected warp moves READY->WAITING and the rr pointer becomes selected+1 (wraps). Otherwise fe_valid_o clears to 0.
- Back-to-back: a transfer and a new load can occur in the same cycle, so throughput is one request per cycle.
- Latency: launch accepted at edge E0, fe_valid_o high after E1 (2 cycles) with ic_ready_i ignored while empty.
- While fe_valid_o & !ic_ready_i, all fe_* outputs are held stable.
- Update: on upd_valid_i for a WAITING warp:
  - upd_done_i=0: pc<=upd_pc_i, mask<=upd_act_mask_i, state->READY.
  - upd_done_i=1: state->IDLE.
- An update to a non-WAITING warp is ignored; assertion $error outside SYNTHESIS.
- The update is visible to arbitration the next cycle.
- Launch and update in the same cycle: both apply. Launch uses the pre-edge IDLE set, so a warp retired this cycle is launchable only from the next cycle.
- ib_space_i is sampled only at the select/load edge. Dropping it after load does not cancel a request already in the output register.

Test Plan:
- Reset then idle -> fe_valid_o=0, launch_ready_o=1, all_idle_o=1, warp_active_o=8'h00.
- Launch pc=0x10, mask=0xFFFFFFFF, ib_space_i=8'hFF, ic_ready_i=1 -> two cycles later fe_valid_o=1, fe_pc_o=0x10, fe_warp_id_o=0; warp 0 WAITING; no further request until update pc=0x11 -> next request pc=0x11.
- Hold ic_ready_i=0 for 5 cycles with a pending request -> fe_pc_o/fe_act_mask_o/fe_warp_id_o unchanged; on ready, exactly one transfer.
- Launch warps 0-3, each updated immediately, ib_space_i=8'hFF -> id order 0,1,2,3,0,1, one per cycle. With ib_space_i[1]=0 -> order 0,2,3,0.
- Launch 8 warps -> launch_ready_o=0. Update warp 5 with upd_done_i=1 -> warp_active_o[5]=0, launch_ready_o=1, next launch lands in warp 5.
- Assert rst_i while fe_valid_o=1 with warps WAITING -> fe_valid_o=0 immediately, all warps IDLE, the next launch gets warp 0.
